// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, state encoding and address helpers for the D-cache controller
package dcache_pkg;

    localparam int ADDR_WIDTH   = 28;
    localparam int DATA_WIDTH   = 32;
    localparam int BLOCK_SIZE   = 256;
    localparam int INDEX_WIDTH  = 11;
    localparam int WORDS        = BLOCK_SIZE / DATA_WIDTH;
    localparam int OFFSET_WIDTH = $clog2(WORDS);
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int BADDR_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH;

    typedef logic [ADDR_WIDTH-1:0]   addr_t;
    typedef logic [DATA_WIDTH-1:0]   word_t;
    typedef logic [BLOCK_SIZE-1:0]   line_t;
    typedef logic [BADDR_WIDTH-1:0]  baddr_t;
    typedef logic [TAG_WIDTH-1:0]    tag_t;
    typedef logic [INDEX_WIDTH-1:0]  index_t;
    typedef logic [OFFSET_WIDTH-1:0] offset_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_COMPARE,
        ST_WB,
        ST_FILL,
        ST_UPDATE,
        ST_RESP
    } state_e;

    typedef struct packed {
        addr_t addr;
        logic  we;
        word_t wdata;
    } req_t;

    function automatic baddr_t block_addr(input addr_t a);
        return a[ADDR_WIDTH-1:OFFSET_WIDTH];
    endfunction

    function automatic index_t line_index(input addr_t a);
        return a[OFFSET_WIDTH +: INDEX_WIDTH];
    endfunction

    function automatic offset_t word_offset(input addr_t a);
        return a[OFFSET_WIDTH-1:0];
    endfunction

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// rtl/dcache_controller_if.sv - CPU, cache-array and memory-side signal bundle for dcache_controller
interface dcache_controller_if;
    import dcache_pkg::*;

    logic        cpu_req;
    logic        cpu_we;
    addr_t       cpu_addr;
    word_t       cpu_wdata;
    word_t       cpu_rdata;
    logic        cpu_ready;
    logic        cpu_busy;

    addr_t       cache_addr;
    line_t       cache_data_write;
    logic        cache_dirty_write;
    logic        cache_write_en;
    line_t       cache_data_read;
    logic        cache_dirty_read;
    logic        cache_hit;
    logic        cache_valid;
    tag_t        cache_replace_tag;

    baddr_t      mem_addr;
    line_t       mem_wdata;
    logic        mem_we;
    logic        mem_re;
    line_t       mem_rdata;
    logic        mem_ack;

    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_busy,
        output cache_addr, cache_data_write, cache_dirty_write, cache_write_en,
        input  cache_data_read, cache_dirty_read, cache_hit, cache_valid, cache_replace_tag,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata, mem_ack,
        output hit_count, miss_count
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_busy,
        input  cache_addr, cache_data_write, cache_dirty_write, cache_write_en,
        output cache_data_read, cache_dirty_read, cache_hit, cache_valid, cache_replace_tag,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata, mem_ack,
        input  hit_count, miss_count
    );

endinterface

// File: rtl/dcache_word_merge.sv
// rtl/dcache_word_merge.sv - extracts one word from a line and builds the line with that word replaced
module dcache_word_merge
    import dcache_pkg::*;
(
    input  line_t   line_i,
    input  offset_t offset_i,
    input  word_t   wdata_i,
    output word_t   word_o,
    output line_t   line_o
);

    logic [WORDS-1:0][DATA_WIDTH-1:0] words_in;
    logic [WORDS-1:0][DATA_WIDTH-1:0] words_out;

    assign words_in = line_i;

    always_comb begin
        words_out           = words_in;
        words_out[offset_i] = wdata_i;
    end

    assign word_o = words_in[offset_i];
    assign line_o = words_out;

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped D-cache sequencer: hit detect, dirty writeback, refill, store merge
module dcache_controller
    import dcache_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    dcache_controller_if.master bus
);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    line_t       victim_q, victim_d;
    tag_t        victim_tag_q, victim_tag_d;
    line_t       fill_q, fill_d;
    word_t       rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic [31:0] hit_q, hit_d;
    logic [31:0] miss_q, miss_d;

    line_t  merge_src;
    line_t  merge_line;
    word_t  merge_word;

    logic   cache_we_c;
    logic   cache_dirty_c;
    line_t  cache_line_c;
    logic   mem_we_c;
    logic   mem_re_c;
    baddr_t mem_addr_c;

    // COMPARE works on the line just read from the array; UPDATE/RESP work on the refill.
    assign merge_src = (state_q == ST_COMPARE) ? bus.cache_data_read : fill_q;

    dcache_word_merge u_merge (
        .line_i   (merge_src),
        .offset_i (word_offset(req_q.addr)),
        .wdata_i  (req_q.wdata),
        .word_o   (merge_word),
        .line_o   (merge_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            victim_q     <= '0;
            victim_tag_q <= '0;
            fill_q       <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            victim_q     <= victim_d;
            victim_tag_q <= victim_tag_d;
            fill_q       <= fill_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        victim_d      = victim_q;
        victim_tag_d  = victim_tag_q;
        fill_d        = fill_q;
        rdata_d       = rdata_q;
        ready_d       = 1'b0;
        hit_d         = hit_q;
        miss_d        = miss_q;
        cache_we_c    = 1'b0;
        cache_dirty_c = 1'b0;
        cache_line_c  = merge_line;
        mem_we_c      = 1'b0;
        mem_re_c      = 1'b0;
        mem_addr_c    = block_addr(req_q.addr);

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    req_d   = '{addr: bus.cpu_addr, we: bus.cpu_we, wdata: bus.cpu_wdata};
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (bus.cache_hit) begin
                    if (req_q.we) begin
                        cache_we_c    = 1'b1;
                        cache_dirty_c = 1'b1;
                    end else begin
                        rdata_d = merge_word;
                    end
                    ready_d = 1'b1;
                    hit_d   = sat_inc(hit_q);
                    state_d = ST_IDLE;
                end else begin
                    miss_d       = sat_inc(miss_q);
                    victim_d     = bus.cache_data_read;
                    victim_tag_d = bus.cache_replace_tag;
                    state_d      = (bus.cache_valid && bus.cache_dirty_read) ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                mem_we_c   = 1'b1;
                mem_addr_c = {victim_tag_q, line_index(req_q.addr)};
                if (bus.mem_ack) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_re_c = 1'b1;
                if (bus.mem_ack) begin
                    fill_d  = bus.mem_rdata;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                // Ready/rdata are registered here so they are presented during RESP.
                cache_we_c    = 1'b1;
                cache_dirty_c = req_q.we;
                cache_line_c  = req_q.we ? merge_line : fill_q;
                ready_d       = 1'b1;
                if (!req_q.we) begin
                    rdata_d = merge_word;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cpu_rdata         = rdata_q;
    assign bus.cpu_ready         = ready_q;
    assign bus.cpu_busy          = (state_q != ST_IDLE);
    assign bus.cache_addr        = req_q.addr;
    assign bus.cache_data_write  = cache_line_c;
    assign bus.cache_dirty_write = cache_dirty_c;
    assign bus.cache_write_en    = cache_we_c;
    assign bus.mem_addr          = mem_addr_c;
    assign bus.mem_wdata         = victim_q;
    assign bus.mem_we            = mem_we_c;
    assign bus.mem_re            = mem_re_c;
    assign bus.hit_count         = hit_q;
    assign bus.miss_count        = miss_q;

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Sequencer for the direct-mapped D-cache tag/data array (registered-read array: data, tag and dirty appear one clock after the address; hit is combinational on the current address versus the registered tag).
- Accepts single-word CPU load/store requests and detects hit or miss.
- On a miss: writes back the dirty victim block, refills from main memory, then merges the store word.
- Sits between the CPU load/store unit, the cache array and the memory-side block interface.

Parameters:
- ADDR_WIDTH, 28, word address width.
- DATA_WIDTH, 32, CPU word width.
- BLOCK_SIZE, 256, cache line width in bits.
- INDEX_WIDTH, 11, line index bits (2048 lines).
- OFFSET_WIDTH, 3, word-in-line bits, equal to log2(BLOCK_SIZE/DATA_WIDTH).
- TAG_WIDTH, 14, equal to ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH.

Ports:
Clock and reset:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.

CPU side:
- cpu_req  in  1  request strobe, sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  word address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data, valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high in every state except IDLE.

Cache-array side:
- cache_addr  out  ADDR_WIDTH  array address.
- cache_data_write  out  BLOCK_SIZE  line to write.
- cache_dirty_write  out  1  dirty bit to write.
- cache_write_en  out  1  array write strobe.
- cache_data_read  in  BLOCK_SIZE  registered line data.
- cache_dirty_read  in  1  registered dirty bit.
- cache_hit  in  1  valid and tag match.
- cache_valid  in  1  line valid.
- cache_replace_tag  in  TAG_WIDTH  registered victim tag.

Memory side:
- mem_addr  out  ADDR_WIDTH-OFFSET_WIDTH  block address.
- mem_wdata  out  BLOCK_SIZE  writeback line.
- mem_we  out  1  writeback request, level.
- mem_re  out  1  refill request, level.
- mem_rdata  in  BLOCK_SIZE  refill line.
- mem_ack  in  1  one-cycle completion of the current mem_we or mem_re.

- hit_count  out  32  saturating count of hits.
- miss_count  out  32  saturating count of misses.

Behaviour:
Reset:
- rst forces state IDLE.
- All outputs and registers reset to 0: cpu_ready, cpu_rdata, mem_re, mem_we, cache_write_en, counters, latched request.
- Reset mid-operation aborts immediately; mem_re and mem_we drop on the next edge. A pending mem_ack after reset is ignored.

Request capture:
- In IDLE with cpu_req=1, latch addr, we and wdata into req_q; go to READ.
- cpu_req outside IDLE is ignored; the CPU must watch cpu_busy.
- cache_addr is always driven from req_q.addr.

States:
- READ: array samples the address. Next state COMPARE.
- COMPARE:
  - Load hit: next edge cpu_rdata <= word[offset] of cache_data_read, cpu_ready <= 1, hit_count++, go to IDLE.
  - Store hit: cache_write_en=1 this cycle; cache_data_write = cache_data_read with word[offset] replaced by wdata; cache_dirty_write=1. Next edge cpu_ready pulse, hit_count++, go to IDLE.
  - Miss (cache_hit=0): miss_count++; latch victim = cache_data_read and victim_tag = cache_replace_tag. If cache_valid and cache_dirty_read, go to WB; else go to FILL.
- WB:
  - mem_we=1, mem_addr = {victim_tag, index}, mem_wdata = victim.
  - Address and data are held stable until mem_ack. On ack, go to FILL.
  - mem_we is deasserted in the cycle after ack.
- FILL:
  - mem_re=1, mem_addr = req_q.addr[ADDR_WIDTH-1:OFFSET_WIDTH].
  - On mem_ack, latch mem_rdata into fill_q and go to UPDATE.
- UPDATE:
  - cache_write_en=1; cache_data_write = fill_q, with word[offset] replaced by wdata if the request is a store.
  - cache_dirty_write = req_q.we. Go to RESP.
- RESP: cpu_ready pulse; for a load, cpu_rdata = fill_q word[offset]. Go to IDLE.

Latency and rules:
- Hit latency: cpu_ready is high in the cycle after COMPARE, i.e. 3 edges after the accepting edge.
- Miss latency: 3 + (WB wait) + (FILL wait) + 1 cycles.
- cache_write_en is never high outside COMPARE-store-hit and UPDATE, and never for more than one cycle.
- mem_we and mem_re are never high together.
- Counters saturate at 0xFFFFFFFF.
- cpu_rdata holds its value until the next load completes.

Decomposition:
- Shared package dcache_pkg holds:
  - the state encoding (IDLE, READ, COMPARE, WB, FILL, UPDATE, RESP);
  - the width localparams (TAG/INDEX/OFFSET derivation);
  - the block-address slice helper.
- One sub-module, dcache_word_merge: combinational word insert/extract at an offset. It is used in COMPARE, UPDATE and RESP.

Test Plan:
- Cold load, addr 0x0000010 → miss_count=1, mem_re with mem_addr 0x0000002, no mem_we. Ack with a line whose word0 is 0xCAFEF00D → cpu_rdata=0xCAFEF00D, line written clean.
- Repeat load 0x0000010 → cpu_ready exactly 3 edges after accept, hit_count=1, no memory traffic.
- Store 0xDEADBEEF to 0x0000013 (hit) → one-cycle cache_write_en, word3 = 0xDEADBEEF, cache_dirty_write=1, other words unchanged.
- Load 0x0804010 (same index, different tag) → mem_we first with mem_addr 0x0000002 and the dirty line, held across 5 stall cycles until ack. Then mem_re to 0x0100802; the new line is written with dirty=0.
- Store-miss to a clean line → no mem_we; fill line merged with the store word, cache_dirty_write=1. cpu_req pulses during busy are ignored.
- Assert rst during FILL with mem_re high → mem_re=0 next cycle, state IDLE, counters 0. A late mem_ack causes no cache_write_en.
